// File: rtl/fpmul_arb_pkg.sv
// Shared types and constants for the fpmul_arbiter block.
// Optional statistics counters are enabled by defining FPMUL_ARB_STATS_EN.
package fpmul_arb_pkg;

    // Hold/drain controller states
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } arb_state_e;

    // Tag id field is sized for the largest supported requester count (8),
    // so the struct can live here without depending on the top's parameter.
    localparam int TAG_IDW = 3;

    typedef struct packed {
        logic               v;
        logic [TAG_IDW-1:0] id;
    } tag_t;

    localparam logic [63:0] FP_ZERO = 64'h0;

endpackage

// File: rtl/fpmul_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or above the
// pointer, wrapping past NREQ-1 back to 0. Reusable stand-alone.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    // Walk the ring starting at the pointer and latch the first valid hit
    always_comb begin
        logic found;
        int   pos;
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(i_ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!found && i_valid[pos]) begin
                found        = 1'b1;
                o_grant[pos] = 1'b1;
                o_idx        = IDW'(pos);
            end
        end
        o_any = found;
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// Shares one pipelined double-precision multiplier between NREQ requesters.
// Round-robin issue, a tag shift register routes each product back to its
// issuer, and a hold/drain FSM quiesces the datapath on request.
// Define FPMUL_ARB_STATS_EN to add the grant_cnt / busy_cnt counters.
module fpmul_arbiter
    import fpmul_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*64-1:0] req_a,
    input  logic [NREQ*64-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [63:0]       rsp_data,
    output logic [63:0]       mul_a,
    output logic [63:0]       mul_b,
    input  logic [63:0]       mul_pro,
    input  logic              hold,
    output logic              idle
`ifdef FPMUL_ARB_STATS_EN
    ,
    output logic [NREQ*32-1:0] grant_cnt,
    output logic [31:0]        busy_cnt
`endif
);

    localparam int IDW = $clog2(NREQ);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    logic              w_run_ok;
    logic [IDW-1:0]    r_ptr;
    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_idx;
    logic              w_any;
    logic              w_xfer;
    logic [NREQ-1:0]   w_ready;
    logic [63:0]       w_a_arr [NREQ];
    logic [63:0]       w_b_arr [NREQ];
    logic [63:0]       r_mul_a;
    logic [63:0]       r_mul_b;
    tag_t              r_tag [0:MUL_LAT];
    logic [MUL_LAT:0]  w_tag_v;
    logic              w_busy;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [63:0]       r_rsp_data;
    logic              r_idle;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    genvar gi;

    // Unpack the operand buses into per-requester views for the issue mux
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ops
            assign w_a_arr[gi] = req_a[gi*64 +: 64];
            assign w_b_arr[gi] = req_b[gi*64 +: 64];
        end
    endgenerate

    // Collect the valid bit of every tag stage to detect in-flight work
    generate
        for (gi = 0; gi <= MUL_LAT; gi++) begin : g_tagv
            assign w_tag_v[gi] = r_tag[gi].v;
        end
    endgenerate
    assign w_busy = |w_tag_v;

    // Grants are only offered in RUN with hold low; hold wins a tie with valid
    assign w_ready   = (w_run_ok && nrst) ? w_grant : '0;
    assign w_xfer    = w_run_ok && nrst && w_any;
    assign req_ready = w_ready;

    // Next-state logic for the hold/drain controller
    always_comb begin
        w_state_next = r_state;
        w_run_ok     = 1'b0;
        case (r_state)
            RUN: begin
                if (hold) begin
                    w_state_next = DRAIN;
                end else begin
                    w_run_ok = 1'b1;
                end
            end
            DRAIN: begin
                if (!hold) begin
                    w_state_next = RUN;
                end else if (!w_busy) begin
                    w_state_next = PAUSED;
                end
            end
            PAUSED: begin
                if (!hold) begin
                    w_state_next = RUN;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    // State register, round-robin pointer and registered idle flag
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= RUN;
            r_ptr   <= '0;
            r_idle  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idle  <= (w_state_next == PAUSED);
            if (w_xfer) begin
                r_ptr <= (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;
            end
        end
    end

    // Operand issue register: granted operands for one cycle, zero otherwise
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_mul_a <= FP_ZERO;
            r_mul_b <= FP_ZERO;
        end else if (w_xfer) begin
            r_mul_a <= w_a_arr[w_idx];
            r_mul_b <= w_b_arr[w_idx];
        end else begin
            r_mul_a <= FP_ZERO;
            r_mul_b <= FP_ZERO;
        end
    end

    // Tag shift register aligned with the multiplier pipeline
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int k = 0; k <= MUL_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= tag_t'{v: w_xfer, id: TAG_IDW'(w_idx)};
            for (int k = 1; k <= MUL_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Route the product at the pipe tail back to its issuer
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= FP_ZERO;
        end else if (r_tag[MUL_LAT].v) begin
            r_rsp_valid <= NREQ'(1) << r_tag[MUL_LAT].id;
            r_rsp_data  <= mul_pro;
        end else begin
            r_rsp_valid <= '0;
        end
    end

    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign idle      = r_idle;

`ifdef FPMUL_ARB_STATS_EN
    logic [31:0] r_gcnt [NREQ];
    logic [31:0] r_busy_cnt;
    logic        w_stats_clr;

    assign w_stats_clr = (r_state == RUN) && (w_state_next == DRAIN);

    // Saturating activity counters, cleared on reset and on entering DRAIN
    always_ff @(posedge clk) begin
        if (!nrst || w_stats_clr) begin
            for (int k = 0; k < NREQ; k++) begin
                r_gcnt[k] <= '0;
            end
            r_busy_cnt <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (w_ready[k] && req_valid[k] && (r_gcnt[k] != 32'hFFFF_FFFF)) begin
                    r_gcnt[k] <= r_gcnt[k] + 32'd1;
                end
            end
            if (w_busy && (r_busy_cnt != 32'hFFFF_FFFF)) begin
                r_busy_cnt <= r_busy_cnt + 32'd1;
            end
        end
    end

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_gcnt
            assign grant_cnt[gi*32 +: 32] = r_gcnt[gi];
        end
    endgenerate
    assign busy_cnt = r_busy_cnt;
`endif

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Self-checking bench for fpmul_arbiter: random and directed traffic scored
// against a transaction-level model (expected-response queue with due times).
module tb_fpmul_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 4;
    localparam int M_RUN = 0, M_DRAIN = 1, M_PAUSED = 2;

    logic                clk = 1'b0;
    logic                nrst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*64-1:0]  req_a, req_b;
    logic [NREQ-1:0]     rsp_valid;
    logic [63:0]         rsp_data, mul_a, mul_b, mul_pro;
    logic                hold, idle;
    logic [63:0]         opa [NREQ];
    logic [63:0]         opb [NREQ];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_pack
            assign req_a[gi*64 +: 64] = opa[gi];
            assign req_b[gi*64 +: 64] = opb[gi];
        end
    endgenerate

    fpmul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_pro(mul_pro), .hold(hold), .idle(idle)
    );

    function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    // Behavioural multiplier: product appears MUL_LAT cycles after operands
    logic [63:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= fmul(mul_a, mul_b);
        for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_pro = mpipe[MUL_LAT-1];

    typedef struct {
        int          id;
        logic [63:0] p;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          mptr = 0, mstate = M_RUN, cyc = 0;
    logic        midle = 1'b0;
    logic [63:0] mrsp = '0, mma = '0, mmb = '0;
    bit          chk_en = 1'b0;
    int          n_checks = 0, n_fail = 0;
    int          rsp_seen = 0, last_rsp_cyc = -1;
    logic [NREQ-1:0] last_ready;
    logic        last_idle;
    logic [63:0] rd_by_id [NREQ];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rand_fp();
        logic [63:0] m;
        m = {$urandom(), $urandom()};
        return {1'($urandom_range(0, 1)), 11'($urandom_range(900, 1150)), m[51:0]};
    endfunction

    // One clock: score outputs at negedge, advance the model, cross posedge
    task automatic step();
        int g;
        logic [NREQ-1:0] exp_ready, exp_rv;
        logic [63:0] exp_rd;
        bit busy;
        @(negedge clk);
        g = -1;
        if (nrst && mstate == M_RUN && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
            end
        end
        exp_ready = (g >= 0) ? NREQ'(1) << g : '0;
        exp_rv = '0;
        exp_rd = mrsp;
        if (q.size() != 0 && q[0].due == cyc) begin
            exp_rv = NREQ'(1) << q[0].id;
            exp_rd = q[0].p;
        end
        last_ready = req_ready;
        last_idle  = idle;
        if (rsp_valid != '0) begin
            rsp_seen++;
            last_rsp_cyc = cyc;
            for (int k = 0; k < NREQ; k++) if (rsp_valid[k]) rd_by_id[k] = rsp_data;
        end
        if (chk_en) begin
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            check("rsp_data", rsp_data, exp_rd);
            check("mul_a", mul_a, mma);
            check("mul_b", mul_b, mmb);
            check("idle", 64'(idle), 64'(midle));
        end
        if (!nrst) begin
            q.delete();
            mptr = 0; mstate = M_RUN; midle = 1'b0;
            mrsp = '0; mma = '0; mmb = '0;
        end else begin
            if (q.size() != 0 && q[0].due == cyc) begin
                mrsp = q[0].p;
                void'(q.pop_front());
            end
            busy = (q.size() != 0);
            if (g >= 0) begin
                q.push_back('{g, fmul(opa[g], opb[g]), cyc + MUL_LAT + 2});
                mptr = (g + 1) % NREQ;
                mma = opa[g];
                mmb = opb[g];
            end else begin
                mma = '0;
                mmb = '0;
            end
            case (mstate)
                M_RUN:    if (hold) mstate = M_DRAIN;
                M_DRAIN:  if (!hold) mstate = M_RUN; else if (!busy) mstate = M_PAUSED;
                default:  if (!hold) mstate = M_RUN;
            endcase
            midle = (mstate == M_PAUSED);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int t0;
        nrst = 1'b0; hold = 1'b0; req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; rd_by_id[i] = '0; end
        steps(2);
        chk_en = 1'b1;
        nrst = 1'b1;
        step();

        // Single op 1.0 * 2.0 on requester 0
        opa[0] = 64'h3ff0000000000000; opb[0] = 64'h4000000000000000;
        req_valid = 4'b0001; t0 = cyc; step();
        req_valid = '0; steps(10);
        check("latency", 64'(last_rsp_cyc - t0), 64'd6);
        check("one_x_two", rd_by_id[0], 64'h4000000000000000);

        // Wrap and skip: grant 2 moves ptr to 3, then only req1 valid
        req_valid = 4'b0100; step();
        req_valid = 4'b0010; step();
        check("wrap_grant", 64'(last_ready), 64'h2);
        req_valid = 4'b1111; step();
        check("after_wrap", 64'(last_ready), 64'h4);
        req_valid = '0; steps(8);

        // Fairness: all requesters valid for 16 cycles
        begin
            int gcnt [NREQ];
            for (int k = 0; k < NREQ; k++) gcnt[k] = 0;
            req_valid = '1;
            for (int i = 0; i < 16; i++) begin
                for (int k = 0; k < NREQ; k++) begin opa[k] = rand_fp(); opb[k] = rand_fp(); end
                step();
                for (int k = 0; k < NREQ; k++) if (last_ready[k]) gcnt[k]++;
            end
            for (int k = 0; k < NREQ; k++) check("fair_cnt", 64'(gcnt[k]), 64'd4);
        end
        req_valid = '0; steps(10);

        // Drain: three ops in flight then hold until idle
        req_valid = '1; steps(3);
        rsp_seen = 0;
        hold = 1'b1;
        for (int i = 0; i < 30 && !last_idle; i++) step();
        check("drain_idle", 64'(last_idle), 64'd1);
        check("drain_rsp_cnt", 64'(rsp_seen), 64'd3);
        hold = 1'b0; steps(2);
        check("resume_idle", 64'(last_idle), 64'd0);
        check("resume_grant", 64'(|last_ready), 64'd1);
        req_valid = '0; steps(10);

        // Reset mid-flight: two ops issued, then discarded
        req_valid = 4'b0011; steps(2);
        req_valid = '0; nrst = 1'b0; step();
        nrst = 1'b1; rsp_seen = 0; steps(10);
        check("reset_no_rsp", 64'(rsp_seen), 64'd0);

        // Zero and overflow passthrough with routing
        opa[0] = 64'h0; opb[0] = rand_fp();
        req_valid = 4'b0001; step();
        opa[3] = 64'h7fe0000000000000; opb[3] = 64'h7fe0000000000000;
        req_valid = 4'b1000; step();
        req_valid = '0; steps(10);
        check("zero_prod", rd_by_id[0] & 64'h7fffffffffffffff, 64'h0);
        check("ovf_prod", rd_by_id[3], 64'h7ff0000000000000);

        // Random traffic with occasional hold toggling
        for (int i = 0; i < 400; i++) begin
            req_valid = NREQ'($urandom());
            for (int k = 0; k < NREQ; k++) begin opa[k] = rand_fp(); opb[k] = rand_fp(); end
            if ($urandom_range(0, 19) == 0) hold = ~hold;
            step();
        end
        hold = 1'b0; req_valid = '0; steps(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
